// File: rtl/mem_rw_pkg.sv
// Shared encodings and default sizes for the two-port dual-rail memory arbiter.
package mem_rw_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TMO_CYC = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SPACER  = 2'd1,
        ST_DATA    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Dual-rail bus value packed as {RW_t, RW_f}
    localparam logic [1:0] DR_NULL  = 2'b00;
    localparam logic [1:0] DR_READ  = 2'b10;
    localparam logic [1:0] DR_WRITE = 2'b01;

    function automatic logic [1:0] dr_encode(input logic we);
        return we ? DR_WRITE : DR_READ;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer favours the port that was not served last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic       win,
    output logic       any_req
);

    logic pref;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pref <= 1'b0;
        end else if (update) begin
            pref <= ~served;
        end
    end

    assign any_req = |req;
    assign win     = req[pref] ? pref : ~pref;

endmodule

// File: rtl/mem_rw_arbiter.sv
// Two-port (CPU/DMA) arbiter driving a dual-rail NULL/DATA memory handshake with timeout.
//
// state   | meaning
// IDLE    | bus NULL, arbitrate and latch the winner's request
// SPACER  | bus NULL, wait for memory to report NULL (mem_ack = 0)
// DATA    | bus carries read/write, wait for mem_ack = 1
// RELEASE | bus NULL, wait for mem_ack = 0 before freeing the grant
module mem_rw_arbiter
    import mem_rw_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic              PH0,
    input  logic              RES_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              RW_t,
    output logic              RW_f,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int               CNT_W    = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [1:0]       rw_q;
    logic             sel;
    logic             we_q;
    logic             adv;
    logic             tmo_hit;
    logic             rr_update;
    logic             win;
    logic             req_any;

    rr_arb2 u_arb (
        .clk     (PH0),
        .rst_n   (RES_n),
        .req     ({req1, req0}),
        .update  (rr_update),
        .served  (sel),
        .win     (win),
        .any_req (req_any)
    );

    // adv: the handshake condition that lets the current state move on
    always_comb begin
        adv = 1'b0;
        case (state)
            ST_SPACER, ST_RELEASE: adv = !mem_ack;
            ST_DATA:               adv = mem_ack;
            default:               adv = 1'b0;
        endcase
    end

    assign tmo_hit   = (state != ST_IDLE) && !adv && (tmo_cnt == TMO_LAST);
    assign rr_update = tmo_hit || ((state == ST_RELEASE) && adv);
    assign RW_t      = rw_q[1];
    assign RW_f      = rw_q[0];

    always_ff @(posedge PH0 or negedge RES_n) begin
        if (!RES_n) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            rw_q      <= DR_NULL;
            sel       <= 1'b0;
            we_q      <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            err   <= 1'b0;
            if (tmo_hit) begin
                // Abort: free the bus and report completion with error, rdata untouched
                state   <= ST_IDLE;
                tmo_cnt <= '0;
                rw_q    <= DR_NULL;
                gnt0    <= 1'b0;
                gnt1    <= 1'b0;
                done0   <= !sel;
                done1   <= sel;
                err     <= 1'b1;
            end else begin
                if (state != ST_IDLE) begin
                    tmo_cnt <= adv ? '0 : tmo_cnt + CNT_W'(1);
                end
                case (state)
                    ST_IDLE: begin
                        if (req_any) begin
                            sel       <= win;
                            we_q      <= win ? we1 : we0;
                            mem_addr  <= win ? addr1 : addr0;
                            mem_wdata <= win ? wdata1 : wdata0;
                            gnt0      <= !win;
                            gnt1      <= win;
                            tmo_cnt   <= '0;
                            state     <= ST_SPACER;
                        end
                    end
                    ST_SPACER: begin
                        if (adv) begin
                            rw_q  <= dr_encode(we_q);
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (adv) begin
                            if (!we_q) begin
                                rdata <= mem_rdata;
                            end
                            done0 <= !sel;
                            done1 <= sel;
                            rw_q  <= DR_NULL;
                            state <= ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (adv) begin
                            gnt0  <= 1'b0;
                            gnt1  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Scoreboard bench for mem_rw_arbiter: directed scenarios plus randomized two-port traffic
// against a transaction-level reference model and a dual-rail memory responder.
module tb_mem_rw_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int TMO_CYC = 15;

    logic              PH0;
    logic              RES_n;
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, done0, done1, err;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              RW_t, RW_f;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         port;
        bit         we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        bit         err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [logic [15:0]];
    logic [7:0] dev_mem [logic [15:0]];
    bit         ref_pref;
    logic [7:0] ref_rdata;
    bit         stuck;
    logic [1:0]  obs_rw;
    logic [15:0] obs_addr;
    logic [7:0]  obs_wdata;
    logic [1:0]  prev_rw = 2'b00;

    mem_rw_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_CYC(TMO_CYC)) dut (
        .PH0       (PH0),
        .RES_n     (RES_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .RW_t      (RW_t),
        .RW_f      (RW_f),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial begin
        PH0 = 1'b0;
        forever #5 PH0 = ~PH0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Reference model: transactions complete in grant order; pointer favours the other port
    function automatic void predict(input bit port, input bit we, input logic [15:0] addr,
                                    input logic [7:0] wdata, input bit is_err);
        exp_t e;
        if (!is_err) begin
            if (we) ref_mem[addr] = wdata;
            else    ref_rdata     = ref_read(addr);
        end
        e.port  = port;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = ref_rdata;
        e.err   = is_err;
        ref_pref = ~port;
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Memory responder: acknowledges one cycle after the bus changes, returns stored data
    always @(posedge PH0) begin
        if ({RW_t, RW_f} != 2'b00) begin
            obs_rw    <= {RW_t, RW_f};
            obs_addr  <= mem_addr;
            obs_wdata <= mem_wdata;
            if (RW_f) dev_mem[mem_addr] = mem_wdata;
            mem_rdata <= dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : init_val(mem_addr);
        end else begin
            mem_rdata <= 8'($urandom);
        end
        mem_ack <= !stuck && ({RW_t, RW_f} != 2'b00);
    end

    // Protocol invariants
    always @(negedge PH0) begin
        assert (!(RW_t && RW_f)) else begin
            errors++;
            $display("FAIL rw_both_high: RW_t=%0b RW_f=%0b required not both 1", RW_t, RW_f);
        end
        assert (!(gnt0 && gnt1)) else begin
            errors++;
            $display("FAIL gnt_both_high: gnt0=%0b gnt1=%0b required not both 1", gnt0, gnt1);
        end
        assert (!((prev_rw == 2'b10 && {RW_t, RW_f} == 2'b01) ||
                  (prev_rw == 2'b01 && {RW_t, RW_f} == 2'b10))) else begin
            errors++;
            $display("FAIL data_to_data: RW went %b -> %b required NULL between", prev_rw, {RW_t, RW_f});
        end
        assert (!((done0 || done1 || err) && {RW_t, RW_f} != 2'b00)) else begin
            errors++;
            $display("FAIL done_not_null: RW=%b at completion required 00", {RW_t, RW_f});
        end
        prev_rw <= {RW_t, RW_f};
    end

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge PH0);
            if (RES_n === 1'b1 && (done0 || done1)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done0=%0b done1=%0b required no completion", done0, done1);
                end else begin
                    e = exp_q.pop_front();
                    chk("done0", 32'(done0), 32'(!e.port));
                    chk("done1", 32'(done1), 32'(e.port));
                    chk("err", 32'(err), 32'(e.err));
                    chk("rdata", 32'(rdata), 32'(e.rdata));
                    if (!e.err) begin
                        chk("bus_dir", 32'(obs_rw), 32'(e.we ? 2'b01 : 2'b10));
                        chk("bus_addr", 32'(obs_addr), 32'(e.addr));
                        if (e.we) chk("bus_wdata", 32'(obs_wdata), 32'(e.wdata));
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge PH0);
        RES_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        stuck = 1'b0;
        ref_pref = 1'b0;
        ref_rdata = 8'h00;
        exp_q.delete();
        repeat (2) @(negedge PH0);
        RES_n = 1'b1;
    endtask

    // Issue one request per selected port (raised together) and hold each until its done
    task automatic issue(input bit u0, input bit u1, input bit w0, input bit w1,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1, input bit scr);
        bit first, busy0, busy1, scr0, scr1;
        int n;
        first = (u0 && u1) ? ref_pref : u1;
        if (!first) begin
            predict(1'b0, w0, a0, d0, 1'b0);
            if (u1) predict(1'b1, w1, a1, d1, 1'b0);
        end else begin
            predict(1'b1, w1, a1, d1, 1'b0);
            if (u0) predict(1'b0, w0, a0, d0, 1'b0);
        end
        @(negedge PH0);
        if (u0) begin req0 = 1'b1; we0 = w0; addr0 = a0; wdata0 = d0; end
        if (u1) begin req1 = 1'b1; we1 = w1; addr1 = a1; wdata1 = d1; end
        busy0 = u0; busy1 = u1; scr0 = 1'b0; scr1 = 1'b0; n = 0;
        while ((busy0 || busy1) && n < 300) begin
            @(negedge PH0);
            n++;
            if (busy0 && done0) begin
                busy0 = 1'b0; req0 = 1'b0;
            end else if (busy0 && scr && gnt0 && !scr0) begin
                addr0 = 16'($urandom); wdata0 = 8'($urandom); we0 = 1'($urandom_range(0, 1)); scr0 = 1'b1;
            end
            if (busy1 && done1) begin
                busy1 = 1'b0; req1 = 1'b0;
            end else if (busy1 && scr && gnt1 && !scr1) begin
                addr1 = 16'($urandom); wdata1 = 8'($urandom); we1 = 1'($urandom_range(0, 1)); scr1 = 1'b1;
            end
        end
        chk("issue_completed", 32'(busy0 || busy1), 32'(0));
    endtask

    task automatic random_phase();
        int u;
        for (int i = 0; i < 40; i++) begin
            u = int'($urandom_range(1, 3));
            issue(u[0], u[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'(16'h0100 + $urandom_range(0, 7)), 16'(16'h0100 + $urandom_range(0, 7)),
                  8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        int n, start, k, dones;
        int order[3];
        bit got, pg0, pg1;

        RES_n = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        stuck = 1'b0; ref_pref = 1'b0; ref_rdata = 8'h00;
        #1 RES_n = 1'b0;
        #1;
        chk("rst_gnt0", 32'(gnt0), 32'(0));
        chk("rst_gnt1", 32'(gnt1), 32'(0));
        chk("rst_done0", 32'(done0), 32'(0));
        chk("rst_done1", 32'(done1), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_rw", 32'({RW_t, RW_f}), 32'(0));
        chk("rst_rdata", 32'(rdata), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        repeat (2) @(negedge PH0);
        RES_n = 1'b1;

        // Port 0 read of 0x1234, memory returns 0xA5; latency and RW sequence
        dev_mem[16'h1234] = 8'hA5;
        ref_mem[16'h1234] = 8'hA5;
        predict(1'b0, 1'b0, 16'h1234, 8'h00, 1'b0);
        @(negedge PH0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h1234; wdata0 = 8'h00;
        @(negedge PH0);
        chk("lat_e0_rw", 32'({RW_t, RW_f}), 32'(2'b00));
        chk("lat_e0_gnt0", 32'(gnt0), 32'(1));
        @(negedge PH0);
        chk("lat_e1_rw", 32'({RW_t, RW_f}), 32'(2'b10));
        @(negedge PH0);
        chk("lat_e2_done0", 32'(done0), 32'(0));
        @(negedge PH0);
        chk("lat_e3_done0", 32'(done0), 32'(1));
        chk("lat_e3_rw", 32'({RW_t, RW_f}), 32'(2'b00));
        chk("lat_e3_rdata", 32'(rdata), 32'(8'hA5));
        chk("lat_e3_err", 32'(err), 32'(0));
        req0 = 1'b0;

        // Both ports held: round-robin order 0,1,0
        do_reset();
        predict(1'b0, 1'b0, 16'h0020, 8'h00, 1'b0);
        predict(1'b1, 1'b1, 16'h0020, 8'h77, 1'b0);
        predict(1'b0, 1'b0, 16'h0020, 8'h00, 1'b0);
        @(negedge PH0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0020; wdata0 = 8'h00;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 8'h77;
        order = '{-1, -1, -1};
        k = 0; dones = 0; n = 0; pg0 = 1'b0; pg1 = 1'b0;
        while (dones < 3 && n < 200) begin
            @(negedge PH0);
            n++;
            if (gnt0 && !pg0 && k < 3) begin order[k] = 0; k++; end
            if (gnt1 && !pg1 && k < 3) begin order[k] = 1; k++; end
            pg0 = gnt0; pg1 = gnt1;
            if (done0 || done1) dones++;
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_grant_1st", 32'(order[0]), 32'(0));
        chk("rr_grant_2nd", 32'(order[1]), 32'(1));
        chk("rr_grant_3rd", 32'(order[2]), 32'(0));

        // Port 1 write 0x3C to 0x00FF with its inputs disturbed while granted, then read back
        issue(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h00FF, 8'h00, 8'h3C, 1'b1);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0000, 8'h00, 8'h00, 1'b0);

        // mem_ack stuck low: abort after TMO_CYC cycles in DATA
        stuck = 1'b1;
        predict(1'b0, 1'b0, 16'h0300, 8'h00, 1'b1);
        @(negedge PH0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0300;
        start = -1; n = 0; got = 1'b0;
        while (!got && n < 80) begin
            @(negedge PH0);
            n++;
            if (start < 0 && {RW_t, RW_f} != 2'b00) start = n;
            if (err) begin
                got = 1'b1;
                req0 = 1'b0;
                chk("tmo_cycles", 32'(n - start), 32'(TMO_CYC));
                chk("tmo_rw_null", 32'({RW_t, RW_f}), 32'(0));
            end
        end
        chk("tmo_seen", 32'(got), 32'(1));
        stuck = 1'b0;
        issue(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0301, 8'h00, 8'h00, 1'b0);

        random_phase();

        // Reset in the middle of DATA
        @(negedge PH0);
        stuck = 1'b1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0042;
        n = 0;
        while ({RW_t, RW_f} == 2'b00 && n < 40) begin
            @(negedge PH0);
            n++;
        end
        chk("mid_reached_data", 32'({RW_t, RW_f}), 32'(2'b10));
        #2 RES_n = 1'b0;
        #1;
        chk("mid_rst_rw", 32'({RW_t, RW_f}), 32'(0));
        chk("mid_rst_gnt", 32'({gnt0, gnt1}), 32'(0));
        chk("mid_rst_done_err", 32'({done0, done1, err}), 32'(0));
        chk("mid_rst_rdata", 32'(rdata), 32'(0));
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("mid_rst_mem_wdata", 32'(mem_wdata), 32'(0));
        req1 = 1'b0; stuck = 1'b0;
        ref_pref = 1'b0; ref_rdata = 8'h00;
        exp_q.delete();
        repeat (2) @(negedge PH0);
        RES_n = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 16'h0105, 16'h0106, 8'h00, 8'h00, 1'b0);

        repeat (4) @(negedge PH0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_rw_arbiter.md
MEM_RW_ARBITER -- requirements
Module: mem_rw_arbiter

Interface
REQ-001 Parameters: ADDR_W, 16, address width; DATA_W, 8, data width; TMO_CYC, 15, cycles allowed per mem_ack wait before abort.
REQ-002 Clocking SHALL be exactly this: one clock; reset is asynchronous and active-low.
REQ-003 Ports, clock and reset first:
- PH0  in  1  system clock, rising edge
- RES_n  in  1  async active-low reset
- req0/req1  in  1  access request, port 0 = CPU, port 1 = DMA
- we0/we1  in  1  1 = write, 0 = read
- addr0/addr1  in  ADDR_W  access address
- wdata0/wdata1  in  DATA_W  write data
- gnt0/gnt1  out  1  port owns memory
- done0/done1  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, on timeout
- rdata  out  DATA_W  captured read data
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- RW_t/RW_f  out  1  dual-rail R/W; 00 = NULL, 10 = read, 01 = write
- mem_rdata  in  DATA_W  memory read data
- mem_ack  in  1  memory completion detect; 1 = DATA accepted, 0 = NULL accepted

Function
REQ-004 All outputs SHALL be registered on PH0.
REQ-005 FSM states SHALL be IDLE, SPACER, DATA, RELEASE.
REQ-006 IDLE: RW = NULL; on any req, arbitrate, latch addr/we/wdata of the winner, assert its gnt, go to SPACER.
REQ-007 SPACER: RW = NULL; when mem_ack = 0 is sampled, go to DATA.
REQ-008 DATA: RW_t = ~we, RW_f = we; when mem_ack = 1 is sampled, capture mem_rdata into rdata on reads, pulse done for the granted port, go to RELEASE.
REQ-009 RELEASE: RW = NULL; when mem_ack = 0 is sampled, drop gnt, update the round-robin pointer, go to IDLE.
REQ-010 RW_t and RW_f SHALL never both be 1; transitions SHALL always pass through NULL (DATA to DATA is illegal).
REQ-011 Arbitration SHALL be round-robin: on simultaneous requests, grant the port not served last; after reset, port 0 has priority.
REQ-012 A single requester SHALL be granted back-to-back with no idle penalty beyond one IDLE cycle.
REQ-013 Deasserting req during a transaction SHALL be ignored; the transaction completes.
REQ-014 Changing addr/we/wdata while gnt is high SHALL NOT affect mem_addr or mem_wdata.
REQ-015 Timeout: a counter SHALL clear on each state entry. If it reaches TMO_CYC in SPACER, DATA or RELEASE, the block drives NULL, pulses done and err for the granted port, leaves rdata unchanged, and returns to IDLE.
REQ-016 rdata SHALL hold its value until the next successful read.
REQ-017 Nominal read latency (mem_ack follows RW in one cycle) SHALL be: req sampled at edge 0, done high after edge 3.

Reset
REQ-018 RES_n low SHALL asynchronously force: state = IDLE, RW_t = RW_f = 0, gnt/done/err = 0, rdata/mem_addr/mem_wdata = 0, timeout counter = 0, round-robin pointer = port 0 preferred.
REQ-019 Reset during DATA SHALL drop RW to NULL immediately, without waiting for PH0.

Structure
REQ-020 Package mem_rw_pkg SHALL hold the state encoding, the dual-rail constants (DR_NULL = 00, DR_READ = 10, DR_WRITE = 01) and the default widths.
REQ-021 One sub-module, rr_arb2, SHALL implement the two-way round-robin arbiter with a pointer-update input; all other logic is flat.

Verification
REQ-022 Reset then port 0 reads 0x1234 with a memory model returning 0xA5 -> RW sequence 00,10,00; done0 after edge 3; rdata = 0xA5; err = 0.
REQ-023 req0 and req1 in the same cycle, both held -> gnt0 first, then gnt1, then gnt0; never both gnt high.
REQ-024 Port 1 writes 0x3C to 0x00FF -> RW = 01 in DATA, mem_wdata = 0x3C, mem_addr = 0x00FF, rdata unchanged.
REQ-025 mem_ack stuck at 0 in DATA -> err and done pulse after TMO_CYC = 15 cycles; RW returns to 00; next request serviced normally.
REQ-026 RES_n asserted mid-DATA -> RW = 00 within the same cycle; all outputs at reset values; port 0 wins the next arbitration.
REQ-027 Throughout all tests, a bench assertion SHALL check RW_t & RW_f = 0 and a NULL state between any two DATA states.
